// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types and rotating-priority search for the mux arbiter
package mux_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } rr_pick_t;

    // Search begins one past last_ptr and wraps 3->0; the first set request wins.
    function automatic rr_pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                         input logic [SEL_W-1:0]   last_ptr);
        rr_pick_t         res;
        logic [SEL_W-1:0] cand;
        res = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = last_ptr + SEL_W'(i);
            if (!res.found && req[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux4.sv
// rtl/mux_rr_arbiter_mux4.sv - plain 4:1 data mux driven by the arbiter's direction
module mux4 #(
    parameter int DATA_WIDTH = 2
) (
    input  logic [1:0]            sel_i,
    input  logic [DATA_WIDTH-1:0] in0_i,
    input  logic [DATA_WIDTH-1:0] in1_i,
    input  logic [DATA_WIDTH-1:0] in2_i,
    input  logic [DATA_WIDTH-1:0] in3_i,
    output logic [DATA_WIDTH-1:0] y_o
);

    always_comb begin
        y_o = in0_i;
        case (sel_i)
            2'd0:    y_o = in0_i;
            2'd1:    y_o = in1_i;
            2'd2:    y_o = in2_i;
            default: y_o = in3_i;
        endcase
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter with bounded tenure sharing one 4:1 mux
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_WIDTH  = 2,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [3:0]            req_i,
    input  logic [DATA_WIDTH-1:0] data0_i,
    input  logic [DATA_WIDTH-1:0] data1_i,
    input  logic [DATA_WIDTH-1:0] data2_i,
    input  logic [DATA_WIDTH-1:0] data3_i,
    output logic [3:0]            grant_o,
    output logic [1:0]            direction_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    localparam logic [7:0] HOLD_MAX = 8'(HOLD_CYCLES);

    arb_state_t             state_q, state_d;
    logic [7:0]             hold_cnt_q, hold_cnt_d;
    logic [SEL_W-1:0]       last_ptr_q, last_ptr_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [SEL_W-1:0]       dir_q, dir_d;
    logic                   valid_q, valid_d;
    logic [DATA_WIDTH-1:0]  mux_y;

    rr_pick_t pick;
    logic     holding;

    assign pick    = rr_pick(req_i, last_ptr_q);
    // The holder keeps the mux only while still requesting and under its tenure limit.
    assign holding = (state_q == GRANT) && req_i[dir_q] && (hold_cnt_q < HOLD_MAX);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            last_ptr_q <= 2'd3;
            grant_q    <= '0;
            dir_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            last_ptr_q <= last_ptr_d;
            grant_q    <= grant_d;
            dir_q      <= dir_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = pick.found ? GRANT : IDLE;
            GRANT:   state_d = (holding || pick.found) ? GRANT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        last_ptr_d = last_ptr_q;
        grant_d    = grant_q;
        dir_d      = dir_q;
        valid_d    = valid_q;
        if (holding) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
        end else if (pick.found) begin
            hold_cnt_d = 8'd1;
            last_ptr_d = pick.idx;
            grant_d    = 4'b0001 << pick.idx;
            dir_d      = pick.idx;
            valid_d    = 1'b1;
        end else begin
            hold_cnt_d = '0;
            grant_d    = '0;
            valid_d    = 1'b0;
        end
    end

    mux4 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mux4 (
        .sel_i(dir_q),
        .in0_i(data0_i),
        .in1_i(data1_i),
        .in2_i(data2_i),
        .in3_i(data3_i),
        .y_o  (mux_y)
    );

    assign grant_o     = grant_q;
    assign direction_o = dir_q;
    assign valid_o     = valid_q;
    assign data_o      = valid_q ? mux_y : '0;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - randomized and directed checks of mux_rr_arbiter against a behavioural model
module tb_mux_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [1:0] d [4];

    logic [3:0] g0, g1;
    logic [1:0] dir0, dir1;
    logic       v0, v1;
    logic [1:0] do0, do1;

    int n_tests = 0;
    int n_fail  = 0;

    // model state per DUT: index 0 has tenure 4, index 1 has tenure 1
    int m_own  [2];
    int m_ten  [2];
    int m_last [2];
    int m_dir  [2];

    always #5 clk = ~clk;

    mux_rr_arbiter #(.DATA_WIDTH(2), .HOLD_CYCLES(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .req_i(req),
        .data0_i(d[0]), .data1_i(d[1]), .data2_i(d[2]), .data3_i(d[3]),
        .grant_o(g0), .direction_o(dir0), .valid_o(v0), .data_o(do0)
    );

    mux_rr_arbiter #(.DATA_WIDTH(2), .HOLD_CYCLES(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req),
        .data0_i(d[0]), .data1_i(d[1]), .data2_i(d[2]), .data3_i(d[3]),
        .grant_o(g1), .direction_o(dir1), .valid_o(v1), .data_o(do1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_own[k]  = -1;
            m_ten[k]  = 0;
            m_last[k] = 3;
            m_dir[k]  = 0;
        end
    endtask

    task automatic model_step(input logic [3:0] r);
        int h, w, c;
        for (int k = 0; k < 2; k++) begin
            h = (k == 0) ? 4 : 1;
            if (m_own[k] >= 0 && r[m_own[k]] && m_ten[k] < h) begin
                m_ten[k]++;
            end else begin
                w = -1;
                for (int j = 1; j <= 4; j++) begin
                    c = (m_last[k] + j) % 4;
                    if (w < 0 && r[c]) w = c;
                end
                if (w >= 0) begin
                    m_own[k] = w; m_ten[k] = 1; m_last[k] = w; m_dir[k] = w;
                end else begin
                    m_own[k] = -1; m_ten[k] = 0;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [3:0] eg;
        logic [1:0] ed;
        for (int k = 0; k < 2; k++) begin
            eg = (m_own[k] < 0) ? 4'b0000 : (4'b0001 << m_own[k]);
            ed = (m_own[k] < 0) ? 2'b00 : d[m_own[k]];
            if (k == 0) begin
                chk({tag, "_grant4"}, g0, eg);
                chk({tag, "_valid4"}, v0, m_own[k] >= 0);
                chk({tag, "_dir4"}, dir0, m_dir[k]);
                chk({tag, "_data4"}, do0, ed);
            end else begin
                chk({tag, "_grant1"}, g1, eg);
                chk({tag, "_valid1"}, v1, m_own[k] >= 0);
                chk({tag, "_dir1"}, dir1, m_dir[k]);
                chk({tag, "_data1"}, do1, ed);
            end
        end
    endtask

    // Called at a falling edge: apply req, advance the model, and check after the next rising edge.
    task automatic drive(input logic [3:0] r, input string tag);
        req = r;
        model_step(r);
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    // Asserted between edges so the async clear is visible without any clock.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        chk({tag, "_rst_grant"}, {g1, g0}, 8'h00);
        chk({tag, "_rst_valid"}, {v1, v0}, 2'b00);
        chk({tag, "_rst_data"}, {do1, do0}, 4'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        check_all({tag, "_post"});
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        for (int i = 0; i < 4; i++) d[i] = 2'(i);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        check_all("reset");

        // single request, then held for 10 cycles
        d[2] = 2'b10;
        drive(4'b0100, "single");
        chk("single_grant", g0, 4'b0100);
        chk("single_dir", dir0, 2);
        chk("single_data", do0, 2'b10);
        for (int i = 0; i < 10; i++) begin
            drive(4'b0100, "single_hold");
            chk("single_hold_grant", g0, 4'b0100);
        end

        // reset mid-grant with other requests pending, then requester 0 first
        req = 4'b0101;
        @(posedge clk);
        #2;
        do_reset("midgrant");
        drive(4'b0101, "after_rst");
        chk("after_rst_grant", g0, 4'b0001);

        // full contention from a fresh reset
        do_reset("contend");
        for (int i = 0; i < 20; i++) begin
            drive(4'b1111, "contend");
            chk("contend_rot4", g0, 4'b0001 << ((i / 4) % 4));
            chk("contend_rot1", g1, 4'b0001 << (i % 4));
            chk("contend_valid", v0, 1'b1);
        end

        // early release from 1 to 3
        do_reset("early");
        drive(4'b0010, "early_g1");
        chk("early_g1", g0, 4'b0010);
        drive(4'b1010, "early_hold");
        chk("early_hold", g0, 4'b0010);
        drive(4'b1000, "early_rel");
        chk("early_rel_grant", g0, 4'b1000);
        chk("early_rel_valid", v0, 1'b1);

        // wrap-around: holder 3 expires with req 1001, next goes to 0
        for (int i = 0; i < 3; i++) drive(4'b1001, "wrap_hold");
        chk("wrap_still3", g0, 4'b1000);
        drive(4'b1001, "wrap");
        chk("wrap_grant", g0, 4'b0001);

        // go idle then a fresh request
        drive(4'b0001, "idle_pre");
        drive(4'b0000, "idle");
        chk("idle_valid", v0, 1'b0);
        chk("idle_data", do0, 2'b00);
        drive(4'b0010, "idle_new");
        chk("idle_new_grant", g0, 4'b0010);

        // randomized traffic with occasional resets and mid-cycle data changes
        for (int i = 0; i < 400; i++) begin
            for (int j = 0; j < 4; j++) d[j] = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) begin
                do_reset("rnd");
            end else begin
                drive(4'($urandom), "rnd");
                d[dir0] = ~d[dir0];
                #1;
                chk("rnd_comb_data", do0, v0 ? d[dir0] : 2'b00);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
